alu_arbiter: RTL and testbench

Shares one combinational ALU instance between two requesters, typically the integer pipeline's execute stage (port 0) and a multi-cycle helper such as an address or CSR sequencer (port 1). Each port has a valid/ready request channel and a valid/ready response channel. The block arbitrates round-robin, registers the winning operation, drives the ALU for one cycle and holds the captured result until the owning requester accepts it. One transaction is outstanding at a time.

---
 rtl/alu_arbiter_if.sv | 48 ++++
 rtl/alu_arbiter.sv | 123 ++++++++++++
 tb/tb_alu_arbiter.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter_if
// Description : Request/response bundle between two requesters and the shared
//               ALU arbiter.
//               Port 0 request : req0_valid, req0_ready, req0_op, req0_a, req0_b
//               Port 1 request : req1_valid, req1_ready, req1_op, req1_a, req1_b
//               Responses      : rsp0_valid/rsp0_ready, rsp1_valid/rsp1_ready,
//                                rsp_result (shared, qualified by rspN_valid)
//               master = requester side, slave = arbiter side.
// Revision    : 1.0  initial release
// ============================================================================
interface alu_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [4:0]  req0_op;
  logic [31:0] req0_a;
  logic [31:0] req0_b;

  logic        req1_valid;
  logic        req1_ready;
  logic [4:0]  req1_op;
  logic [31:0] req1_a;
  logic [31:0] req1_b;

  logic        rsp0_valid;
  logic        rsp0_ready;
  logic        rsp1_valid;
  logic        rsp1_ready;
  logic [31:0] rsp_result;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid, rsp_result
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid, rsp_result
  );
endinterface
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Round-robin sharing of one combinational ALU between two
//               requesters. One transaction in flight: accept (IDLE), drive the
//               ALU for one cycle (EXEC), hold the result until the owner takes
//               it (RESP).
// Ports       : clk        - rising-edge clock
//               rst        - asynchronous active-high reset
//               bus        - request/response channels (slave modport)
//               alu_op     - opcode to ALU (zero outside EXEC)
//               alu_a/b    - operands to ALU (zero outside EXEC)
//               alu_result - result from ALU, captured at the end of EXEC
//               busy       - high whenever the FSM is not idle
// Revision    : 1.0  initial release
// ============================================================================
module alu_arbiter (
  input  wire logic        clk,
  input  wire logic        rst,
  alu_arbiter_if.slave     bus,
  output logic [4:0]       alu_op,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  input  wire logic [31:0] alu_result,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state_q,      state_d;
  logic        last_grant_q, last_grant_d;
  logic        owner_q,      owner_d;
  logic [4:0]  op_q,         op_d;
  logic [31:0] a_q,          a_d;
  logic [31:0] b_q,          b_d;
  logic [31:0] result_q,     result_d;

  // Port 1 wins when it is the only requester, or when both request and
  // port 0 was the last one served. Otherwise port 0 wins.
  logic grant;
  assign grant = bus.req1_valid && (!bus.req0_valid || !last_grant_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      op_q         <= 5'd0;
      a_q          <= 32'd0;
      b_q          <= 32'd0;
      result_q     <= 32'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      result_q     <= result_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    owner_d        = owner_q;
    op_d           = op_q;
    a_d            = a_q;
    b_d            = b_q;
    result_d       = result_q;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.rsp0_valid = 1'b0;
    bus.rsp1_valid = 1'b0;
    alu_op         = 5'd0;
    alu_a          = 32'd0;
    alu_b          = 32'd0;

    case (state_q)
      ST_IDLE: begin
        bus.req0_ready = bus.req0_valid && !grant;
        bus.req1_ready = bus.req1_valid &&  grant;
        // Operands are sampled only here; later changes on the request
        // inputs cannot disturb the in-flight operation.
        if (bus.req0_valid || bus.req1_valid) begin
          owner_d      = grant;
          last_grant_d = grant;
          op_d         = grant ? bus.req1_op : bus.req0_op;
          a_d          = grant ? bus.req1_a  : bus.req0_a;
          b_d          = grant ? bus.req1_b  : bus.req0_b;
          state_d      = ST_EXEC;
        end
      end
      ST_EXEC: begin
        alu_op   = op_q;
        alu_a    = a_q;
        alu_b    = b_q;
        result_d = alu_result;
        state_d  = ST_RESP;
      end
      ST_RESP: begin
        bus.rsp0_valid = !owner_q;
        bus.rsp1_valid =  owner_q;
        // Only the owner's ready completes the transaction.
        if (owner_q ? bus.rsp1_ready : bus.rsp0_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.rsp_result = result_q;
  assign busy           = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Self-checking bench for alu_arbiter with a behavioural ALU,
//               directed stimulus and a response scoreboard.
// Revision    : 1.0  initial release
// ============================================================================
module tb_alu_arbiter;

  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;
  localparam logic [4:0] OP_SLL = 5'd2;
  localparam logic [4:0] OP_SRA = 5'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_result;
  logic        busy;

  alu_arbiter_if bus_if ();

  alu_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus_if),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Behavioural ALU with the bench's own opcode encoding.
  always_comb begin
    alu_result = alu_a ^ alu_b;
    case (alu_op)
      OP_ADD: alu_result = alu_a + alu_b;
      OP_SUB: alu_result = alu_a - alu_b;
      OP_SLL: alu_result = alu_a << alu_b[4:0];
      OP_SRA: alu_result = $unsigned($signed(alu_a) >>> alu_b[4:0]);
      default: alu_result = alu_a ^ alu_b;
    endcase
  end

  typedef struct packed {
    logic        port;
    logic [31:0] res;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic port, input logic [31:0] res);
    exp_t e;
    e.port = port;
    e.res  = res;
    sb_q.push_back(e);
  endtask

  // Monitor: pops the scoreboard on every response handshake.
  always @(negedge clk) begin
    if (!rst) begin
      chk("rsp_onehot", {95'd0, bus_if.rsp0_valid & bus_if.rsp1_valid}, 96'd0);
      if ((bus_if.rsp0_valid && bus_if.rsp0_ready) || (bus_if.rsp1_valid && bus_if.rsp1_ready)) begin
        if (sb_q.size() == 0) begin
          chk("rsp_unexpected", {95'd0, bus_if.rsp1_valid}, {95'd0, !bus_if.rsp1_valid});
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("rsp_port", {95'd0, bus_if.rsp1_valid}, {95'd0, e.port});
          chk("rsp_result", {64'd0, bus_if.rsp_result}, {64'd0, e.res});
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!busy && sb_q.size() == 0) break;
    end
    chk("idle_timeout", {94'd0, busy, sb_q.size() == 0}, {94'd0, 1'b0, 1'b1});
  endtask

  logic [95:0] quiet_vec;
  assign quiet_vec = {21'd0, bus_if.req0_ready, bus_if.req1_ready, bus_if.rsp0_valid,
                      bus_if.rsp1_valid, busy, alu_op, alu_a, alu_b};

  initial begin
    int   n;
    int   cyc_at [4];
    logic gnt    [4];

    bus_if.req0_valid = 1'b0; bus_if.req0_op = 5'd0; bus_if.req0_a = 32'd0; bus_if.req0_b = 32'd0;
    bus_if.req1_valid = 1'b0; bus_if.req1_op = 5'd0; bus_if.req1_a = 32'd0; bus_if.req1_b = 32'd0;
    bus_if.rsp0_ready = 1'b0; bus_if.rsp1_ready = 1'b0;

    // ---- reset and idle ----
    #1 rst = 1'b1;
    @(negedge clk);
    chk("reset_outputs", quiet_vec, 96'd0);
    chk("reset_result", {64'd0, bus_if.rsp_result}, 96'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_quiet", quiet_vec, 96'd0);
    end

    // ---- single add on port 0 ----
    step();
    bus_if.req0_valid = 1'b1; bus_if.req0_op = OP_ADD;
    bus_if.req0_a = 32'd5; bus_if.req0_b = 32'd7; bus_if.rsp0_ready = 1'b1;
    push_exp(1'b0, 32'd12);
    @(negedge clk);
    chk("add_c0_ready", {94'd0, bus_if.req0_ready, bus_if.req1_ready}, {94'd0, 2'b10});
    step();
    bus_if.req0_valid = 1'b0;
    @(negedge clk);
    chk("add_c1_alu", {26'd0, busy, alu_op, alu_a, alu_b}, {26'd0, 1'b1, OP_ADD, 32'd5, 32'd7});
    @(negedge clk);
    chk("add_c2_rsp", {63'd0, bus_if.rsp0_valid, bus_if.rsp_result}, {63'd0, 1'b1, 32'd12});
    @(negedge clk);
    chk("add_c3_idle", {94'd0, busy, bus_if.rsp0_valid}, 96'd0);

    // ---- tie and round-robin from reset ----
    step();
    rst = 1'b1;
    bus_if.req0_valid = 1'b1; bus_if.req0_op = OP_SUB; bus_if.req0_a = 32'd10; bus_if.req0_b = 32'd3;
    bus_if.req1_valid = 1'b1; bus_if.req1_op = OP_SLL; bus_if.req1_a = 32'd1;  bus_if.req1_b = 32'd4;
    bus_if.rsp0_ready = 1'b1; bus_if.rsp1_ready = 1'b1;
    push_exp(1'b0, 32'd7);  push_exp(1'b1, 32'd16);
    push_exp(1'b0, 32'd7);  push_exp(1'b1, 32'd16);
    #2 rst = 1'b0;
    n = 0;
    for (int c = 0; c < 30 && n < 4; c++) begin
      @(negedge clk);
      chk("rr_ready_onehot", {95'd0, bus_if.req0_ready & bus_if.req1_ready}, 96'd0);
      if (bus_if.req0_ready || bus_if.req1_ready) begin
        gnt[n]    = bus_if.req1_ready;
        cyc_at[n] = c;
        n++;
      end
    end
    chk("rr_grant_count", 96'(n), 96'd4);
    for (int i = 0; i < 4 && i < n; i++) begin
      chk("rr_grant_order", {95'd0, gnt[i]}, 96'(i % 2));
      if (i > 0) chk("rr_interval", 96'(cyc_at[i] - cyc_at[i-1]), 96'd3);
    end
    step();
    bus_if.req0_valid = 1'b0; bus_if.req1_valid = 1'b0;
    wait_idle();

    // ---- back-pressure on port 1, port 0 waiting ----
    step();
    bus_if.req1_valid = 1'b1; bus_if.req1_op = OP_SRA;
    bus_if.req1_a = 32'h8000_0000; bus_if.req1_b = 32'd4; bus_if.rsp1_ready = 1'b0;
    push_exp(1'b1, 32'hF800_0000);
    @(negedge clk);
    chk("bp_accept1", {94'd0, bus_if.req0_ready, bus_if.req1_ready}, {94'd0, 2'b01});
    step();
    bus_if.req1_valid = 1'b0;
    bus_if.req0_valid = 1'b1; bus_if.req0_op = OP_ADD; bus_if.req0_a = 32'd2; bus_if.req0_b = 32'd3;
    bus_if.rsp0_ready = 1'b1;
    push_exp(1'b0, 32'd5);
    @(negedge clk);
    chk("bp_exec_wait", {95'd0, bus_if.req0_ready}, 96'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold", {61'd0, bus_if.rsp1_valid, bus_if.rsp0_valid, bus_if.req0_ready, bus_if.rsp_result},
          {61'd0, 1'b1, 1'b0, 1'b0, 32'hF800_0000});
    end
    step();
    bus_if.rsp1_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", {95'd0, bus_if.rsp1_valid}, {95'd0, 1'b1});
    @(negedge clk);
    chk("bp_port0_grant", {94'd0, bus_if.req0_ready, bus_if.req1_ready}, {94'd0, 2'b10});
    // Operands change the cycle after acceptance; the latched ones must be used.
    step();
    bus_if.req0_valid = 1'b0; bus_if.req0_a = 32'd100;
    @(negedge clk);
    chk("late_change_alu_a", {64'd0, alu_a}, {64'd0, 32'd2});
    wait_idle();

    // ---- reset mid-RESP ----
    step();
    bus_if.req0_valid = 1'b1; bus_if.req0_op = OP_ADD; bus_if.req0_a = 32'd1; bus_if.req0_b = 32'd1;
    bus_if.rsp0_ready = 1'b0;
    @(negedge clk);
    chk("mr_accept", {95'd0, bus_if.req0_ready}, {95'd0, 1'b1});
    step();
    bus_if.req0_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mr_rsp_valid", {95'd0, bus_if.rsp0_valid}, {95'd0, 1'b1});
    #2 rst = 1'b1;
    #1;
    chk("mr_async_drop", {62'd0, bus_if.rsp0_valid, busy, bus_if.rsp_result}, 96'd0);
    step();
    rst = 1'b0;
    bus_if.rsp0_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("mr_no_rsp", {94'd0, bus_if.rsp0_valid, busy}, 96'd0);
    end
    // last_grant is back to 1, so port 0 must win this tie.
    step();
    bus_if.req0_valid = 1'b1; bus_if.req0_op = OP_ADD; bus_if.req0_a = 32'd4; bus_if.req0_b = 32'd4;
    bus_if.req1_valid = 1'b1; bus_if.req1_op = OP_SUB; bus_if.req1_a = 32'd4; bus_if.req1_b = 32'd1;
    push_exp(1'b0, 32'd8);
    push_exp(1'b1, 32'd3);
    @(negedge clk);
    chk("mr_tie_port0", {94'd0, bus_if.req0_ready, bus_if.req1_ready}, {94'd0, 2'b10});
    step();
    bus_if.req0_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus_if.req1_ready) begin
        n = 1;
        break;
      end
    end
    chk("mr_port1_grant", 96'(n), 96'd1);
    step();
    bus_if.req1_valid = 1'b0;
    wait_idle();

    chk("scoreboard_empty", 96'(sb_q.size()), 96'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
